// File: rtl/card_shoe_pkg.sv
// Shared types and helpers for the card shoe: card encoding, deck constants,
// LFSR taps and the shuffle index mask.
package card_shoe_pkg;

    localparam int          DECK_SIZE = 52;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_t;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_SHUFFLE = 2'd1,
        ST_READY   = 2'd2
    } state_t;

    function automatic card_t idx2card(input logic [5:0] n);
        logic [5:0] q;
        logic [5:0] r;
        card_t      c;
        q      = n / 6'd13;
        r      = n % 6'd13;
        c.suit = q[1:0];
        c.rank = r[3:0] + 4'd1;
        return c;
    endfunction

    // Smallest all-ones mask covering i, so the masked LFSR draw rejects as rarely as possible.
    function automatic logic [5:0] idx_mask(input logic [5:0] i);
        logic [5:0] m;
        if (i > 6'd31)      m = 6'd63;
        else if (i > 6'd15) m = 6'd31;
        else if (i > 6'd7)  m = 6'd15;
        else if (i > 6'd3)  m = 6'd7;
        else if (i > 6'd1)  m = 6'd3;
        else                m = 6'd1;
        return m;
    endfunction

endpackage

// File: rtl/card_shoe_lfsr16.sv
// Free-running 16-bit Galois LFSR; advances every cycle and reloads SEED on reset.
module lfsr16
    import card_shoe_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [15:0] o_state
);

    // Right-shifting Galois step, taps applied when the bit shifted out is 1.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_state <= SEED;
        end else begin
            o_state <= {1'b0, o_state[15:1]} ^ (o_state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/card_shoe.sv
// 52-card shoe: identity load, Fisher-Yates shuffle from a free-running LFSR,
// then one card per accepted draw request.
module card_shoe
    import card_shoe_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_drawReq,
    input  logic       i_shuffle,
    output card_t      o_card,
    output logic       o_cardValid,
    output logic       o_busy,
    output logic       o_empty,
    output logic [5:0] o_remaining
);

    state_t      r_state;
    state_t      w_next_state;
    logic [5:0]  r_deck [DECK_SIZE];
    logic [5:0]  r_top;
    logic [5:0]  r_i;
    logic [15:0] w_lfsr;
    logic [5:0]  w_j;
    logic        w_swap;
    logic        w_accept;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_state (w_lfsr)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, swap decision and draw acceptance; a shuffle command overrides all.
    always_comb begin
        w_next_state = r_state;
        w_swap       = 1'b0;
        w_accept     = 1'b0;
        w_j          = w_lfsr[5:0] & idx_mask(r_i);
        case (r_state)
            ST_LOAD: begin
                w_next_state = ST_SHUFFLE;
            end
            ST_SHUFFLE: begin
                if (w_j <= r_i) begin
                    w_swap = 1'b1;
                    if (r_i == 6'd1) begin
                        w_next_state = ST_READY;
                    end else begin
                        w_next_state = ST_SHUFFLE;
                    end
                end else begin
                    w_swap = 1'b0;
                end
            end
            ST_READY: begin
                w_accept = i_drawReq && !o_cardValid && (o_remaining != 6'd0);
            end
            default: begin
                w_next_state = ST_LOAD;
            end
        endcase
        if (i_shuffle) begin
            w_next_state = ST_LOAD;
            w_accept     = 1'b0;
        end else begin
            w_accept     = w_accept;
        end
    end

    // Deck storage, shuffle pointer, deal pointer and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_top       <= 6'd0;
            r_i         <= 6'd51;
            o_cardValid <= 1'b0;
            o_card      <= '0;
            o_busy      <= 1'b1;
            o_empty     <= 1'b0;
            o_remaining <= 6'd0;
        end else begin
            o_cardValid <= w_accept;
            if (i_shuffle) begin
                o_busy      <= 1'b1;
                o_empty     <= 1'b0;
                o_remaining <= 6'd0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        for (int k = 0; k < DECK_SIZE; k++) begin
                            r_deck[k] <= 6'(k);
                        end
                        r_i <= 6'd51;
                    end
                    ST_SHUFFLE: begin
                        if (w_swap) begin
                            r_deck[r_i] <= r_deck[w_j];
                            r_deck[w_j] <= r_deck[r_i];
                            r_i         <= r_i - 6'd1;
                            if (r_i == 6'd1) begin
                                r_top       <= 6'd0;
                                o_remaining <= 6'd52;
                                o_busy      <= 1'b0;
                            end
                        end
                    end
                    ST_READY: begin
                        if (w_accept) begin
                            o_card      <= idx2card(r_deck[r_top]);
                            r_top       <= r_top + 6'd1;
                            o_remaining <= o_remaining - 6'd1;
                            o_empty     <= (o_remaining == 6'd1);
                        end
                    end
                    default: begin
                        o_busy <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
